flag_unit: RTL and testbench

- Consumes the ALU's 4-bit Flags output: bit0 Z, bit1 C, bit2 V, bit3 N.
- Holds the architectural status register and evaluates 4-bit branch condition codes against it, with a registered take/not-take result.
- Keeps a small LIFO shadow stack so interrupt entry can save the flags and return can restore them.
- Sits between the ALU and the control/sequencer, opposite the ALU on the flags interface.

---
 rtl/flag_unit.sv | 129 ++++++++++++
 tb/tb_flag_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flag_unit: status register, branch condition evaluation, flag LIFO stack |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module flag_unit #(
  parameter int DEPTH = 4,
  parameter int PW    = 3
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [3:0] AluFlags,
  input  logic       FlagsWe,
  input  logic       CondValid,
  input  logic [3:0] CondCode,
  input  logic       SaveReq,
  input  logic       RestoreReq,
  input  logic       ErrClr,
  output logic [3:0] Flags,
  output logic       Take,
  output logic       TakeValid,
  output logic       StackEmpty,
  output logic       StackFull,
  output logic       StackErr
);

  localparam logic [3:0] CC_AL = 4'd0,  CC_EQ = 4'd1,  CC_NE = 4'd2,  CC_CS = 4'd3,
                         CC_CC = 4'd4,  CC_MI = 4'd5,  CC_PL = 4'd6,  CC_VS = 4'd7,
                         CC_VC = 4'd8,  CC_HI = 4'd9,  CC_LS = 4'd10, CC_GE = 4'd11,
                         CC_LT = 4'd12, CC_GT = 4'd13, CC_LE = 4'd14, CC_NV = 4'd15;

  logic [3:0]    stack_mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_idx;
  logic [3:0]    top_entry;
  logic [3:0]    next_flags;
  logic          empty;
  logic          full;
  logic          push_ok;
  logic          pop_ok;
  logic          push_err;
  logic          pop_err;

  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
    logic z, c, v, n;
    logic res;
    z = f[0];
    c = f[1];
    v = f[2];
    n = f[3];
    case (code)
      CC_AL:   res = 1'b1;
      CC_EQ:   res = z;
      CC_NE:   res = !z;
      CC_CS:   res = c;
      CC_CC:   res = !c;
      CC_MI:   res = n;
      CC_PL:   res = !n;
      CC_VS:   res = v;
      CC_VC:   res = !v;
      CC_HI:   res = c & !z;
      CC_LS:   res = !c | z;
      CC_GE:   res = (n == v);
      CC_LT:   res = (n != v);
      CC_GT:   res = !z & (n == v);
      CC_LE:   res = z | (n != v);
      CC_NV:   res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign empty      = (ptr == '0);
  assign full       = (ptr == PW'(DEPTH));
  assign StackEmpty = empty;
  assign StackFull  = full;

  // Simultaneous save and restore cancel each other and are not an error.
  assign push_ok  = SaveReq & ~RestoreReq & ~full;
  assign pop_ok   = RestoreReq & ~SaveReq & ~empty;
  assign push_err = SaveReq & ~RestoreReq & full;
  assign pop_err  = RestoreReq & ~SaveReq & empty;

  assign top_idx = ptr - PW'(1);

  always_comb begin
    top_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (top_idx == PW'(i)) top_entry = stack_mem[i];
    end
  end

  always_comb begin
    next_flags = Flags;
    if (pop_ok)       next_flags = top_entry;
    else if (FlagsWe) next_flags = AluFlags;
  end

  // A push stores the pre-edge flags, not the value being loaded this cycle.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) stack_mem[i] <= '0;
    end else if (push_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ptr == PW'(i)) stack_mem[i] <= Flags;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ptr       <= '0;
      Flags     <= '0;
      Take      <= 1'b0;
      TakeValid <= 1'b0;
      StackErr  <= 1'b0;
    end else begin
      Flags     <= next_flags;
      TakeValid <= CondValid;
      if (CondValid) Take <= cond_eval(CondCode, next_flags);
      if (push_ok)     ptr <= ptr + PW'(1);
      else if (pop_ok) ptr <= ptr - PW'(1);
      if (push_err || pop_err) StackErr <= 1'b1;
      else if (ErrClr)         StackErr <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_flag_unit: directed self-checking bench for flag_unit                 |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_flag_unit;

  logic       Clock;
  logic       nReset;
  logic [3:0] AluFlags;
  logic       FlagsWe;
  logic       CondValid;
  logic [3:0] CondCode;
  logic       SaveReq;
  logic       RestoreReq;
  logic       ErrClr;
  logic [3:0] Flags;
  logic       Take;
  logic       TakeValid;
  logic       StackEmpty;
  logic       StackFull;
  logic       StackErr;

  int checks = 0;
  int errors = 0;

  flag_unit #(.DEPTH(4), .PW(3)) dut (
    .Clock(Clock), .nReset(nReset), .AluFlags(AluFlags), .FlagsWe(FlagsWe),
    .CondValid(CondValid), .CondCode(CondCode), .SaveReq(SaveReq),
    .RestoreReq(RestoreReq), .ErrClr(ErrClr), .Flags(Flags), .Take(Take),
    .TakeValid(TakeValid), .StackEmpty(StackEmpty), .StackFull(StackFull),
    .StackErr(StackErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference condition table: Z=f[0], C=f[1], V=f[2], N=f[3].
  function automatic logic model_cond(input logic [3:0] code, input logic [3:0] f);
    case (code)
      4'd0:    return 1'b1;
      4'd1:    return f[0];
      4'd2:    return ~f[0];
      4'd3:    return f[1];
      4'd4:    return ~f[1];
      4'd5:    return f[3];
      4'd6:    return ~f[3];
      4'd7:    return f[2];
      4'd8:    return ~f[2];
      4'd9:    return f[1] & ~f[0];
      4'd10:   return ~f[1] | f[0];
      4'd11:   return ~(f[3] ^ f[2]);
      4'd12:   return f[3] ^ f[2];
      4'd13:   return ~f[0] & ~(f[3] ^ f[2]);
      4'd14:   return f[0] | (f[3] ^ f[2]);
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    AluFlags = '0; FlagsWe = 0; CondValid = 0; CondCode = '0;
    SaveReq = 0; RestoreReq = 0; ErrClr = 0;
  endtask

  task automatic test_reset();
    nReset = 0;
    idle();
    #3;
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", Flags); end
    checks++; if (Take !== 1'b0) begin errors++; $display("FAIL reset_take: got %b want 0", Take); end
    checks++; if (TakeValid !== 1'b0) begin errors++; $display("FAIL reset_takevalid: got %b want 0", TakeValid); end
    checks++; if (StackEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", StackEmpty); end
    checks++; if (StackFull !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", StackFull); end
    checks++; if (StackErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", StackErr); end
    step();
    nReset = 1;
    step();
  endtask

  task automatic test_eq();
    FlagsWe = 1; AluFlags = 4'b0001;
    step();
    idle();
    checks++; if (Flags !== 4'b0001) begin errors++; $display("FAIL eq_load: got %b want 0001", Flags); end
    CondValid = 1; CondCode = 4'd1;
    step();
    idle();
    checks++; if (Take !== 1'b1) begin errors++; $display("FAIL eq_take: got %b want 1", Take); end
    checks++; if (TakeValid !== 1'b1) begin errors++; $display("FAIL eq_valid: got %b want 1", TakeValid); end
    step();
    checks++; if (TakeValid !== 1'b0) begin errors++; $display("FAIL eq_valid_drop: got %b want 0", TakeValid); end
    checks++; if (Take !== 1'b1) begin errors++; $display("FAIL eq_take_hold: got %b want 1", Take); end
  endtask

  task automatic test_bypass();
    // Flags is 0001 here; NE must see the same-cycle load of 0000.
    FlagsWe = 1; AluFlags = 4'b0000; CondValid = 1; CondCode = 4'd2;
    step();
    idle();
    checks++; if (Take !== 1'b1) begin errors++; $display("FAIL bypass_ne: got %b want 1", Take); end
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL bypass_flags: got %b want 0000", Flags); end
  endtask

  task automatic test_back_to_back();
    logic exp;
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        FlagsWe = 1; AluFlags = 4'(f); CondValid = 1; CondCode = 4'(c);
        exp = model_cond(4'(c), 4'(f));
        step();
        checks++;
        if (Take !== exp || TakeValid !== 1'b1) begin
          errors++;
          $display("FAIL sweep f=%0d cc=%0d: take=%b valid=%b want take=%b valid=1", f, c, Take, TakeValid, exp);
        end
      end
    end
    idle();
    step();
    checks++; if (TakeValid !== 1'b0) begin errors++; $display("FAIL sweep_end_valid: got %b want 0", TakeValid); end
  endtask

  task automatic test_save_restore();
    FlagsWe = 1; AluFlags = 4'b1010;
    step();
    idle(); SaveReq = 1;
    step();
    idle();
    checks++; if (StackEmpty !== 1'b0) begin errors++; $display("FAIL sr_not_empty: got %b want 0", StackEmpty); end
    FlagsWe = 1; AluFlags = 4'b0101;
    step();
    idle();
    checks++; if (Flags !== 4'b0101) begin errors++; $display("FAIL sr_load: got %b want 0101", Flags); end
    RestoreReq = 1;
    step();
    idle();
    checks++; if (Flags !== 4'b1010) begin errors++; $display("FAIL sr_restore: got %b want 1010", Flags); end
    checks++; if (StackEmpty !== 1'b1) begin errors++; $display("FAIL sr_empty: got %b want 1", StackEmpty); end
  endtask

  task automatic test_save_with_we();
    FlagsWe = 1; AluFlags = 4'b0011;
    step();
    SaveReq = 1; FlagsWe = 1; AluFlags = 4'b1100;
    step();
    idle();
    checks++; if (Flags !== 4'b1100) begin errors++; $display("FAIL sw_load: got %b want 1100", Flags); end
    RestoreReq = 1;
    step();
    idle();
    checks++; if (Flags !== 4'b0011) begin errors++; $display("FAIL sw_restore: got %b want 0011", Flags); end
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < 4; i++) begin
      FlagsWe = 1; AluFlags = 4'(i + 1);
      step();
      idle(); SaveReq = 1;
      step();
      idle();
    end
    checks++; if (StackFull !== 1'b1) begin errors++; $display("FAIL ov_full: got %b want 1", StackFull); end
    checks++; if (StackErr !== 1'b0) begin errors++; $display("FAIL ov_no_err: got %b want 0", StackErr); end
    FlagsWe = 1; AluFlags = 4'b1001;
    step();
    idle(); SaveReq = 1;
    step();
    idle();
    checks++; if (StackErr !== 1'b1) begin errors++; $display("FAIL ov_err: got %b want 1", StackErr); end
    checks++; if (Flags !== 4'b1001) begin errors++; $display("FAIL ov_flags: got %b want 1001", Flags); end
    ErrClr = 1;
    step();
    idle();
    checks++; if (StackErr !== 1'b0) begin errors++; $display("FAIL ov_clr: got %b want 0", StackErr); end
    SaveReq = 1; RestoreReq = 1;
    step();
    idle();
    checks++; if (StackErr !== 1'b0 || StackFull !== 1'b1 || Flags !== 4'b1001) begin
      errors++; $display("FAIL both_req: err=%b full=%b flags=%b want 0 1 1001", StackErr, StackFull, Flags);
    end
    for (int i = 0; i < 4; i++) begin
      RestoreReq = 1;
      step();
      idle();
      checks++; if (Flags !== 4'(4 - i)) begin errors++; $display("FAIL ov_pop%0d: got %b want %b", i, Flags, 4'(4 - i)); end
    end
    checks++; if (StackEmpty !== 1'b1) begin errors++; $display("FAIL un_empty: got %b want 1", StackEmpty); end
    RestoreReq = 1; FlagsWe = 1; AluFlags = 4'b0110;
    step();
    idle();
    checks++; if (Flags !== 4'b0110) begin errors++; $display("FAIL un_flags: got %b want 0110", Flags); end
    checks++; if (StackErr !== 1'b1) begin errors++; $display("FAIL un_err: got %b want 1", StackErr); end
    ErrClr = 1;
    step();
    idle();
    checks++; if (StackErr !== 1'b0) begin errors++; $display("FAIL un_clr: got %b want 0", StackErr); end
    ErrClr = 1; RestoreReq = 1;
    step();
    idle();
    checks++; if (StackErr !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", StackErr); end
    ErrClr = 1;
    step();
    idle();
    checks++; if (StackErr !== 1'b0) begin errors++; $display("FAIL final_clr: got %b want 0", StackErr); end
  endtask

  task automatic test_async_reset();
    FlagsWe = 1; AluFlags = 4'b0111;
    step();
    idle(); SaveReq = 1;
    step();
    SaveReq = 1; CondValid = 1; CondCode = 4'd0;
    step();
    idle();
    checks++; if (TakeValid !== 1'b1 || StackEmpty !== 1'b0 || Flags !== 4'b0111) begin
      errors++; $display("FAIL ar_pre: valid=%b empty=%b flags=%b want 1 0 0111", TakeValid, StackEmpty, Flags);
    end
    #2;
    nReset = 0;
    #1;
    checks++; if (Flags !== 4'b0000 || Take !== 1'b0 || TakeValid !== 1'b0) begin
      errors++; $display("FAIL ar_regs: flags=%b take=%b valid=%b want 0000 0 0", Flags, Take, TakeValid);
    end
    checks++; if (StackEmpty !== 1'b1 || StackFull !== 1'b0 || StackErr !== 1'b0) begin
      errors++; $display("FAIL ar_stack: empty=%b full=%b err=%b want 1 0 0", StackEmpty, StackFull, StackErr);
    end
    step();
    nReset = 1;
    RestoreReq = 1;
    step();
    idle();
    checks++; if (StackErr !== 1'b1 || Flags !== 4'b0000) begin
      errors++; $display("FAIL ar_post_pop: err=%b flags=%b want 1 0000", StackErr, Flags);
    end
  endtask

  initial begin
    test_reset();
    test_eq();
    test_bypass();
    test_back_to_back();
    test_save_restore();
    test_save_with_we();
    test_overflow_underflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
